// File: rtl/pcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pcm_pkg
//  Purpose  : Shared widths, line-code mask and field struct for the PCM
//             companding codec.
//  Revision : 1.0  initial release
// ============================================================================
package pcm_pkg;

    localparam int LOG_W  = 8;
    localparam int LIN_W  = 13;
    localparam int SEG_W  = 3;
    localparam int MANT_W = 4;

    localparam logic [LOG_W-1:0] EVEN_MASK = 8'h55;

    typedef struct packed {
        logic              sign;
        logic [SEG_W-1:0]  seg;
        logic [MANT_W-1:0] mant;
    } seg_fields_t;

endpackage : pcm_pkg
`default_nettype wire

// File: rtl/pcm_seg_encode.sv
`default_nettype none
// ============================================================================
//  Module   : pcm_seg_encode
//  Purpose  : Combinational priority encoder, 12-bit magnitude to the log
//             segment number and truncated 4-bit mantissa.
//  Revision : 1.0  initial release
// ============================================================================
module pcm_seg_encode
    import pcm_pkg::*;
(
    input  logic [LIN_W-2:0]  i_mag,
    output logic [SEG_W-1:0]  o_seg,
    output logic [MANT_W-1:0] o_mant
);

    logic [SEG_W-1:0] w_seg;
    logic [SEG_W-1:0] w_shift;

    // Highest set bit at or above 5 wins; below 32 the segment stays 0.
    always_comb begin
        w_seg = '0;
        for (int p = 5; p < LIN_W - 1; p++) begin
            if (i_mag[p]) begin
                w_seg = SEG_W'(p - 4);
            end
        end
    end

    // Segment 0 has the same step size as segment 1, so both shift by one.
    assign w_shift = (w_seg == '0) ? SEG_W'(1) : w_seg;
    assign o_seg   = w_seg;
    assign o_mant  = MANT_W'(i_mag >> w_shift);

endmodule : pcm_seg_encode
`default_nettype wire

// File: rtl/pcm_compander_stream.sv
`default_nettype none
// ============================================================================
//  Module   : pcm_compander_stream
//  Purpose  : Two-stage streaming log/linear PCM compander with channel tags,
//             valid/ready back-pressure and saturating debug counters.
//  Revision : 1.0  initial release
// ============================================================================
module pcm_compander_stream
    import pcm_pkg::*;
#(
    parameter int CH_W        = 3,
    parameter int INVERT_EVEN = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_dir,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [LIN_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_dir,
    output logic [CH_W-1:0]  out_ch,
    output logic [LIN_W-1:0] out_data,
    output logic [CNT_W-1:0] cnt_expand,
    output logic [CNT_W-1:0] cnt_compress,
    input  logic             cnt_clear
);

    localparam logic [LOG_W-1:0] c_mask    = (INVERT_EVEN != 0) ? EVEN_MASK : '0;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic              w_advance;
    logic [LOG_W-1:0]  w_code;
    logic [SEG_W-1:0]  w_enc_seg;
    logic [MANT_W-1:0] w_enc_mant;
    seg_fields_t       w_s1_next;

    logic              r_s1_valid;
    logic              r_s1_dir;
    logic [CH_W-1:0]   r_s1_ch;
    seg_fields_t       r_s1_f;

    logic [LIN_W-2:0]  w_exp_base;
    logic [LIN_W-2:0]  w_exp_mag;
    logic [LOG_W-1:0]  w_log;
    logic [LIN_W-1:0]  w_result;

    logic              r_out_valid;
    logic              r_out_dir;
    logic [CH_W-1:0]   r_out_ch;
    logic [LIN_W-1:0]  r_out_data;
    logic [CNT_W-1:0]  r_cnt_expand;
    logic [CNT_W-1:0]  r_cnt_compress;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_code    = in_data[LOG_W-1:0] ^ c_mask;

    pcm_seg_encode u_seg_encode (
        .i_mag  (in_data[LIN_W-2:0]),
        .o_seg  (w_enc_seg),
        .o_mant (w_enc_mant)
    );

    always_comb begin
        w_s1_next = '0;
        if (in_dir) begin
            w_s1_next.sign = in_data[LIN_W-1];
            w_s1_next.seg  = w_enc_seg;
            w_s1_next.mant = w_enc_mant;
        end else begin
            w_s1_next = seg_fields_t'(w_code);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_dir   <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_f     <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_dir <= in_dir;
                r_s1_ch  <= in_ch;
                r_s1_f   <= w_s1_next;
            end
        end
    end

    // Expand: implicit leading one above the mantissa (except segment 0) and
    // a half-step bias bit below it.
    assign w_exp_base = {6'b0, 1'b1, r_s1_f.mant, 1'b1};
    assign w_exp_mag  = (r_s1_f.seg == '0) ? {7'b0, r_s1_f.mant, 1'b1}
                                           : (w_exp_base << (r_s1_f.seg - SEG_W'(1)));
    assign w_log      = {r_s1_f.sign, r_s1_f.seg, r_s1_f.mant} ^ c_mask;
    assign w_result   = r_s1_dir ? {5'b0, w_log} : {r_s1_f.sign, w_exp_mag};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_dir   <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_dir  <= r_s1_dir;
                r_out_ch   <= r_s1_ch;
                r_out_data <= w_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            r_cnt_expand   <= '0;
            r_cnt_compress <= '0;
        end else if (r_out_valid && out_ready) begin
            if (r_out_dir) begin
                if (r_cnt_compress != c_cnt_max) r_cnt_compress <= r_cnt_compress + 1'b1;
            end else begin
                if (r_cnt_expand != c_cnt_max) r_cnt_expand <= r_cnt_expand + 1'b1;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_dir      = r_out_dir;
    assign out_ch       = r_out_ch;
    assign out_data     = r_out_data;
    assign cnt_expand   = r_cnt_expand;
    assign cnt_compress = r_cnt_compress;

endmodule : pcm_compander_stream
`default_nettype wire

// File: doc/pcm_compander_stream.md
Name: pcm_compander_stream

Overview:
Streaming, pipelined companding codec between the 13-bit sign-magnitude linear PCM domain and the 8-bit segmented log PCM domain.
- Direction is selected per sample: expand (log to linear) or compress (linear to log).
- Each sample carries a channel tag through the pipeline, so one instance serves several interleaved voice channels of the FSK modem front end.
- A valid/ready handshake with back-pressure sits on both sides; a saturating per-direction sample counter supports debug.

Parameters:
CH_W, 3, width of the channel tag carried alongside each sample (1..8)
INVERT_EVEN, 0, 1 = XOR the log code with 8'h55 on the log side (line-code even-bit inversion), applied to the expand input and the compress output
CNT_W, 16, width of each saturating sample counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input sample present
in_ready  out  1  block accepts the input this cycle
in_dir  in  1  0 = expand, 1 = compress
in_ch  in  CH_W  channel tag
in_data  in  13  expand: [7:0] = log code, [12:8] ignored; compress: sign-magnitude linear, [12] = sign
out_valid  out  1  result present
out_ready  in  1  downstream accepts the result
out_dir  out  1  direction of the result
out_ch  out  CH_W  channel tag of the result
out_data  out  13  expand: linear result; compress: {5'b0, log code}
cnt_expand  out  CNT_W  saturating count of completed expand transfers
cnt_compress  out  CNT_W  saturating count of completed compress transfers
cnt_clear  in  1  synchronous clear of both counters

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset: out_valid=0, out_dir=0, out_ch=0, out_data=0, counters=0, all internal stage valids=0. in_ready=1 in the first cycle after reset.
- Reset during operation discards all in-flight samples. Nothing is emitted for them.
- Two-stage pipeline.
  - S1 registers sign, segment and mantissa, plus dir and ch.
  - S2 registers the assembled result.
  - Latency is 2 cycles from an accepted input to out_valid while unstalled.
- Stall rule:
  - advance = !out_valid || out_ready.
  - All stages move together when advance=1.
  - in_ready = advance.
  - Input is accepted on in_valid && in_ready.
  - A bubble (in_valid=0 while advancing) clears the S1 valid.
- While out_valid=1 and out_ready=0, out_* hold stable and no new input is accepted.
- Throughput is one sample per cycle with out_ready tied high.
- Expand, with code c = in_data[7:0] ^ (INVERT_EVEN ? 8'h55 : 0):
  - sign = c[7], seg = c[6:4], m = c[3:0].
  - Magnitude (12 bits) = seg==0 ? {7'b0, m, 1'b1} : ({1'b1, m, 1'b1} << (seg-1)).
  - out_data = {sign, magnitude}.
- Compress, with sign = in_data[12] and mag = in_data[11:0]:
  - If mag < 32: seg = 0, m = mag[4:1].
  - Otherwise: p = index of the MSB of mag (5..11), seg = p-4, m = mag[seg+3:seg].
  - Code = {sign, seg, m} ^ (INVERT_EVEN ? 8'h55 : 0).
  - Truncation only; no rounding.
- Round trip: compress(expand(x)) == x for all 256 codes.
- Negative zero (13'h1000) compresses to 8'h80 (sign preserved).
- Counters:
  - Increment on out_valid && out_ready, selected by out_dir.
  - Saturate at all-ones; never wrap.
  - cnt_clear has priority over a simultaneous increment.
- Mixed directions and channel tags may be interleaved back-to-back with no dead cycle.
- Outputs are in strict input order.

Decomposition:
- Shared package pcm_pkg holds:
  - constants LOG_W=8, LIN_W=13, SEG_W=3, MANT_W=4, EVEN_MASK=8'h55;
  - typedef seg_fields_t {sign, seg, mant}.
- One natural sub-module: pcm_seg_encode.
  - Combinational priority encoder, 12-bit magnitude to {seg, mant}.
  - Instantiated in S1.
- Expand shift logic and the handshake/pipeline control stay in the top module.

Test Plan:
- Expand 8'h35, ch=2, INVERT_EVEN=0 -> 2 cycles later out_data=13'h00AC, out_ch=2, out_dir=0; expand 8'h80 -> 13'h1001.
- Compress 13'h1FFF -> 8'hFF; compress 13'h0010 -> 8'h08; compress 13'h0000 -> 8'h00; compress 13'h1000 -> 8'h80.
- Sweep all 256 codes expand then compress, with both INVERT_EVEN=0 and 1 -> every code returns unchanged.
- Stream 6 samples, hold out_ready=0 for cycles 3-7 -> in_ready=0 during the hold, out_data stable, no loss or duplication, order preserved, cnt totals exact.
- Assert rst with 2 samples in flight -> out_valid=0 the next cycle, counters=0, dropped samples never appear.
- Force cnt_expand to saturation with CNT_W=4: 20 expands -> counter holds 4'hF; cnt_clear together with a transfer -> counter reads 0.
